// File: rtl/pic_init_sequencer.sv
// 8259 initialization sequencer: walks ICW1..ICW4, holds the configuration and forwards OCW commands.
// Optional feature macro: PIC_CASCADE_EN (ICW3 state and cascade_config register).
module pic_init_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] internal_data_bus,
  input  logic       write_initial_command_word_1_reset,
  input  logic       write_initial_command_word_2_4,
  input  logic       write_operation_control_word_1,
  input  logic       write_operation_control_word_2,
  input  logic       write_operation_control_word_3,
  output logic       init_done,
  output logic       ltim,
  output logic       single_mode,
  output logic       adi,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_config,
  output logic       upm,
  output logic       auto_eoi,
  output logic       buffer_master,
  output logic       buffered_mode,
  output logic       special_fully_nested,
  output logic [7:0] interrupt_mask,
  output logic       read_register_isr,
  output logic       special_mask_mode,
  output logic       ocw2_valid,
  output logic [7:0] ocw2_data,
  output logic       poll_command
);

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  localparam int ICW1 = 0;
  localparam int ICW24 = 1;
  localparam int OCW1 = 2;
  localparam int OCW2 = 3;
  localparam int OCW3 = 4;

`ifdef PIC_CASCADE_EN
  localparam logic [4:0] ICW4_MASK = 5'b11111;
`else
  localparam logic [4:0] ICW4_MASK = 5'b10011;
`endif

  logic [4:0] stb_in_r;
  logic [4:0] stb_q_r;
  logic [4:0] stb_qq_r;
  logic [4:0] commit_s;
  logic [7:0] data_in_r;
  logic [7:0] data_q_r;
  state_t     state_r;
  state_t     state_next_s;
  logic       cascade_seq_s;
  logic       load_icw1_s;
  logic       load_vb_s;
  logic       load_icw4_s;
  logic       load_mask_s;
  logic       load_ocw2_s;
  logic       load_ocw3_s;

  // Input sampling and strobe delay chain; a write commits on the trailing edge of its strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stb_in_r  <= 5'b0;
      stb_q_r   <= 5'b0;
      stb_qq_r  <= 5'b0;
      data_in_r <= 8'h00;
      data_q_r  <= 8'h00;
    end else begin
      stb_in_r  <= {write_operation_control_word_3, write_operation_control_word_2,
                    write_operation_control_word_1, write_initial_command_word_2_4,
                    write_initial_command_word_1_reset};
      stb_q_r   <= stb_in_r;
      stb_qq_r  <= stb_q_r;
      data_in_r <= internal_data_bus;
      if (|stb_in_r) begin
        data_q_r <= data_in_r;
      end
    end
  end

  assign commit_s = stb_qq_r & ~stb_q_r;

`ifdef PIC_CASCADE_EN
  assign cascade_seq_s = ~single_mode;
`else
  assign cascade_seq_s = 1'b0;
`endif

  // State register; init_done tracks the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= UNINIT;
      init_done <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      init_done <= (state_next_s == READY);
    end
  end

  // Next-state logic; ICW1 restarts the sequence from any state.
  always_comb begin
    state_next_s = state_r;
    if (commit_s[ICW1]) begin
      state_next_s = WAIT_ICW2;
    end else if (commit_s[ICW24]) begin
      case (state_r)
        WAIT_ICW2: begin
          if (cascade_seq_s) begin
            state_next_s = WAIT_ICW3;
          end else if (ic4) begin
            state_next_s = WAIT_ICW4;
          end else begin
            state_next_s = READY;
          end
        end
        WAIT_ICW3: state_next_s = ic4 ? WAIT_ICW4 : READY;
        WAIT_ICW4: state_next_s = READY;
        default:   state_next_s = state_r;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Action decode; ICW1 discards every other commit of the same cycle.
  always_comb begin
    load_icw1_s = commit_s[ICW1];
    load_vb_s   = 1'b0;
    load_icw4_s = 1'b0;
    load_mask_s = 1'b0;
    load_ocw2_s = 1'b0;
    load_ocw3_s = 1'b0;
    if (!commit_s[ICW1]) begin
      load_vb_s   = commit_s[ICW24] && (state_r == WAIT_ICW2);
      load_icw4_s = commit_s[ICW24] && (state_r == WAIT_ICW4);
      load_mask_s = commit_s[OCW1] && (state_r == READY);
      load_ocw2_s = commit_s[OCW2] && (state_r == READY);
      load_ocw3_s = commit_s[OCW3] && (state_r == READY);
    end else begin
      load_vb_s   = 1'b0;
    end
  end

  // Configuration registers and command pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {ltim, adi, single_mode, ic4} <= 4'b0;
      vector_base       <= 5'h00;
      {special_fully_nested, buffered_mode, buffer_master, auto_eoi, upm} <= 5'b0;
      interrupt_mask    <= 8'h00;
      read_register_isr <= 1'b0;
      special_mask_mode <= 1'b0;
      ocw2_valid        <= 1'b0;
      ocw2_data         <= 8'h00;
      poll_command      <= 1'b0;
    end else begin
      ocw2_valid   <= load_ocw2_s;
      poll_command <= load_ocw3_s && data_q_r[2];
      if (load_icw1_s) begin
        {ltim, adi, single_mode, ic4} <= data_q_r[3:0];
        {special_fully_nested, buffered_mode, buffer_master, auto_eoi, upm} <= 5'b0;
        interrupt_mask    <= 8'h00;
        read_register_isr <= 1'b0;
        special_mask_mode <= 1'b0;
      end else begin
        if (load_vb_s) begin
          vector_base <= data_q_r[7:3];
        end
        if (load_icw4_s) begin
          {special_fully_nested, buffered_mode, buffer_master, auto_eoi, upm} <= data_q_r[4:0] & ICW4_MASK;
        end
        if (load_mask_s) begin
          interrupt_mask <= data_q_r;
        end
        if (load_ocw2_s) begin
          ocw2_data <= data_q_r;
        end
        if (load_ocw3_s && data_q_r[1]) begin
          read_register_isr <= data_q_r[0];
        end
        if (load_ocw3_s && data_q_r[6]) begin
          special_mask_mode <= data_q_r[5];
        end
      end
    end
  end

`ifdef PIC_CASCADE_EN
  // Cascade configuration survives ICW1 and is only rewritten by ICW3.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cascade_config <= 8'h00;
    end else if (!commit_s[ICW1] && commit_s[ICW24] && (state_r == WAIT_ICW3)) begin
      cascade_config <= data_q_r;
    end
  end
`else
  assign cascade_config = 8'h00;
`endif

endmodule

// File: doc/pic_init_sequencer.md
# pic_init_sequencer

Initialization and operation-command sequencer for the 8259 PIC core. Consumes the decoded write strobes and `internal_data_bus` from the bus control logic and walks the ICW1→ICW2→(ICW3)→(ICW4) sequence. Holds the resulting configuration registers (vector base, cascade, mode bits, interrupt mask, read select) and forwards OCW2/OCW3 commands to the priority and in-service logic.

## Interface
- No parameters.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `internal_data_bus` input 8: write data from bus control.
- `write_initial_command_word_1_reset` input 1: ICW1 strobe, level, high for the whole write.
- `write_initial_command_word_2_4` input 1: A0=1 write strobe; may coincide with OCW1 strobe.
- `write_operation_control_word_1` / `_2` / `_3` input 1 each: OCW strobes, level.
- `init_done` output 1: sequence complete (state READY).
- `ltim`, `single_mode`, `adi`, `ic4` output 1 each: ICW1 bits 3, 1, 2, 0.
- `vector_base` output 5: ICW2[7:3].
- `cascade_config` output 8: ICW3.
- `upm`, `auto_eoi`, `buffer_master`, `buffered_mode`, `special_fully_nested` output 1 each: ICW4 bits 0–4.
- `interrupt_mask` output 8: OCW1 (IMR).
- `read_register_isr` output 1: 0 = read IRR, 1 = read ISR.
- `special_mask_mode` output 1.
- `ocw2_valid` output 1: one-cycle pulse; `ocw2_data` output 8 is valid with it.
- `poll_command` output 1: one-cycle pulse.

## Operation
- **Commit rule:** each strobe is registered (`*_q`). While the strobe is high, the data is latched into `data_q` every cycle. A write commits in the cycle where `strobe_q=1` and `strobe=0`; that is the trailing edge of the write and matches the 8259 latching on the WR rising edge.
- **States:** UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- **ICW1 commit, from any state, including mid-sequence:**
  - Latch ic4, single_mode, adi, ltim.
  - Clear interrupt_mask to 8'h00, read_register_isr, special_mask_mode and all ICW4 fields; keep cascade_config.
  - Go to WAIT_ICW2.
- **WAIT_ICW2 + ICW2_4 commit:**
  - vector_base ← data_q[7:3].
  - Next state: WAIT_ICW3 if !single_mode; else WAIT_ICW4 if ic4; else READY.
- **WAIT_ICW3 + ICW2_4 commit:**
  - cascade_config ← data_q.
  - Next state: WAIT_ICW4 if ic4, else READY.
- **WAIT_ICW4 + ICW2_4 commit:** ICW4 fields ← data_q[4:0]; go to READY.
- **READY, OCW1 commit:** interrupt_mask ← data_q.
- **READY, OCW2 commit:** ocw2_valid=1 and ocw2_data=data_q for exactly one cycle.
- **READY, OCW3 commit:**
  - If data_q[1] (RR): read_register_isr ← data_q[0].
  - If data_q[6] (ESMM): special_mask_mode ← data_q[5].
  - If data_q[2] (P): pulse poll_command for one cycle.
- **Not READY:** OCW1/2/3 commits are ignored, and ICW2_4 commits in UNINIT are ignored. During init, a coincident OCW1 strobe is consumed as ICW data only; interrupt_mask is unchanged.
- **Simultaneous commits:** ICW1 has priority and the other commits in that cycle are discarded. OCW commits in the same cycle apply independently.
- **Reset:** state=UNINIT, every register and output = 0, pulses low, strobe/data regs cleared. Reset asserted mid-sequence aborts immediately and asynchronously.

## Timing
- Commit latency: configuration outputs, `init_done` and pulses change on the rising edge that ends the commit cycle. That edge is 2 edges after the first edge that samples the strobe low.
- Pulses last exactly 1 clock. Back-to-back writes need ≥1 idle cycle between strobes; minimum strobe width is 1 cycle.
- `init_done` deasserts on the edge completing an ICW1 commit.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `PIC_CASCADE_EN` defined: WAIT_ICW3 state, `cascade_config` register and the single_mode branch operate as above.
- `PIC_CASCADE_EN` undefined:
  - The single_mode bit is still reported but treated as 1 for sequencing; WAIT_ICW3 is never entered.
  - `cascade_config` is tied to 8'h00.
  - ICW4 bits 2 and 3 are forced to 0.

## Test plan
- Reset, then ICW1=8'h13 (single, IC4), ICW2=8'h48, ICW4=8'h03 → vector_base=5'h09, upm=1, auto_eoi=1, init_done=1 after the ICW4 commit, interrupt_mask=8'h00.
- ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h01:
  - With the macro: cascade_config=8'h04 and init_done=1 only after the 4th write.
  - Without the macro: the 3rd write (8'h04) is taken as ICW4, giving upm=0, auto_eoi=0, init_done=1 after the 3rd write; 4th write ignored.
- In READY, OCW1=8'hA5 → interrupt_mask=8'hA5; next ICW1=8'h12 → interrupt_mask=8'h00, init_done=0; ICW2=8'h08 → READY, ICW4 fields all 0.
- In READY, OCW2=8'h20 → ocw2_valid high for one cycle with ocw2_data=8'h20. OCW3=8'h0B → read_register_isr=1; OCW3=8'h6C → special_mask_mode=1 and a 1-cycle poll_command; OCW3=8'h08 → read_register_isr unchanged.
- ICW1=8'h13 then ICW2=8'h40, then ICW1=8'h12 again before ICW4 → state WAIT_ICW2 and the old ICW4 fields cleared; OCW1 strobes during init leave interrupt_mask at 8'h00.
- Assert reset for half a cycle while in WAIT_ICW4 → all outputs 0 immediately, state UNINIT; a following ICW2_4 write is ignored.
